// File: rtl/pipe_ctrl.sv
// Stall/bubble/flush sequencer for the 3-stage IF/ID/EX RV32I pipeline.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
   parameter int BOOT_CYCLES   = 2,
   parameter int EXTRA_BUBBLES = 0,
   parameter int MEM_TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        imem_valid,
   input  logic        dmem_req,
   input  logic        dmem_ack,
   input  logic        branch_taken,
   output logic        pc_en,
   output logic        pc_sel_target,
   output logic        ifid_en,
   output logic        ifid_nop,
   output logic        idex_en,
   output logic        idex_nop,
   output logic        mem_err,
   output logic [2:0]  state_o,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {
      S_BOOT     = 2'd0,
      S_RUN      = 2'd1,
      S_MEM_WAIT = 2'd2,
      S_REDIRECT = 2'd3
   } state_t;

   localparam int BC_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BC_W-1:0] BOOT_LAST = BC_W'(BOOT_CYCLES - 1);
   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t          state_q, state_d;
   logic [BC_W-1:0] boot_cnt_q, boot_cnt_d;
   logic [7:0]      wait_q, wait_d;
   logic [2:0]      redir_q, redir_d;
   logic            mem_err_q, mem_err_d;

   always_comb begin
      state_d       = state_q;
      boot_cnt_d    = boot_cnt_q;
      wait_d        = wait_q;
      redir_d       = redir_q;
      mem_err_d     = mem_err_q;
      pc_en         = 1'b0;
      pc_sel_target = 1'b0;
      ifid_en       = 1'b1;
      ifid_nop      = 1'b1;
      idex_en       = 1'b1;
      idex_nop      = 1'b1;
      case (state_q)
         S_BOOT: begin
            boot_cnt_d = boot_cnt_q + BC_W'(1);
            if (boot_cnt_q == BOOT_LAST) begin
               state_d    = S_RUN;
               boot_cnt_d = '0;
            end
         end
         S_RUN: begin
            // An unacked memory access outranks a branch; the branch is re-sampled on exit.
            if (dmem_req && !dmem_ack) begin
               ifid_en   = 1'b0;
               ifid_nop  = 1'b0;
               idex_en   = 1'b0;
               idex_nop  = 1'b0;
               state_d   = S_MEM_WAIT;
               wait_d    = 8'd1;
               if (wait_d >= TIMEOUT) mem_err_d = 1'b1;
            end else if (branch_taken) begin
               pc_en         = 1'b1;
               pc_sel_target = 1'b1;
               if (EXTRA_BUBBLES > 0) begin
                  state_d = S_REDIRECT;
                  redir_d = 3'(EXTRA_BUBBLES);
               end
            end else if (!imem_valid) begin
               idex_nop = 1'b0;
            end else begin
               pc_en    = 1'b1;
               ifid_nop = 1'b0;
               idex_nop = 1'b0;
            end
         end
         S_MEM_WAIT: begin
            ifid_en  = 1'b0;
            ifid_nop = 1'b0;
            idex_en  = 1'b0;
            idex_nop = 1'b0;
            wait_d   = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
            if (wait_d >= TIMEOUT) mem_err_d = 1'b1;
            if (dmem_ack) state_d = S_RUN;
         end
         S_REDIRECT: begin
            pc_en    = imem_valid;
            idex_nop = 1'b0;
            // Only cycles that actually fetch count toward the padding.
            if (imem_valid) begin
               redir_d = redir_q - 3'd1;
               if (redir_q <= 3'd1) state_d = S_RUN;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         boot_cnt_q <= '0;
         wait_q     <= '0;
         redir_q    <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         wait_q     <= wait_d;
         redir_q    <= redir_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;
   assign state_o = {1'b0, state_q};

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_q, stall_d, flush_q, flush_d;
   logic        branch_acc;

   always_comb begin
      branch_acc = (state_q == S_RUN) && branch_taken && !(dmem_req && !dmem_ack);
      stall_d    = stall_q + ((state_q != S_BOOT && !pc_en) ? 32'd1 : 32'd0);
      flush_d    = flush_q + (branch_acc ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (EXTRA_BUBBLES=2/MEM_TIMEOUT=5 and
// EXTRA_BUBBLES=0/MEM_TIMEOUT=255) share stimulus; a negedge monitor drains expectations.
module tb_pipe_ctrl;

   logic clk = 1'b1;
   logic rst_n, imem_valid, dmem_req, dmem_ack, branch_taken;

   logic pc_en_a, sel_a, ifid_en_a, ifid_nop_a, idex_en_a, idex_nop_a, err_a;
   logic pc_en_b, sel_b, ifid_en_b, ifid_nop_b, idex_en_b, idex_nop_b, err_b;
   logic [2:0]  state_a, state_b;
   logic [31:0] stall_a, flush_a, stall_b, flush_b;

   int checks = 0;
   int errors = 0;

   // Expected per-cycle vector: {state[2:0], pc_en, pc_sel, ifid_en, ifid_nop, idex_en, idex_nop, mem_err}
   logic [19:0] exp_q[$];
   string       name_q[$];

   localparam logic [5:0] O_BOOT  = 6'b001111;
   localparam logic [5:0] O_RUN   = 6'b101010;
   localparam logic [5:0] O_STALL = 6'b000000;
   localparam logic [5:0] O_BR    = 6'b111111;
   localparam logic [5:0] O_FBUB  = 6'b001110;
   localparam logic [5:0] O_REDV  = 6'b101110;
   localparam logic [5:0] O_REDI  = 6'b001110;

   always #5 clk = ~clk;

   pipe_ctrl #(.BOOT_CYCLES(2), .EXTRA_BUBBLES(2), .MEM_TIMEOUT(5)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .imem_valid(imem_valid), .dmem_req(dmem_req),
      .dmem_ack(dmem_ack), .branch_taken(branch_taken), .pc_en(pc_en_a),
      .pc_sel_target(sel_a), .ifid_en(ifid_en_a), .ifid_nop(ifid_nop_a),
      .idex_en(idex_en_a), .idex_nop(idex_nop_a), .mem_err(err_a), .state_o(state_a),
      .stall_cycles(stall_a), .flush_count(flush_a)
   );

   pipe_ctrl #(.BOOT_CYCLES(2), .EXTRA_BUBBLES(0), .MEM_TIMEOUT(255)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .imem_valid(imem_valid), .dmem_req(dmem_req),
      .dmem_ack(dmem_ack), .branch_taken(branch_taken), .pc_en(pc_en_b),
      .pc_sel_target(sel_b), .ifid_en(ifid_en_b), .ifid_nop(ifid_nop_b),
      .idex_en(idex_en_b), .idex_nop(idex_nop_b), .mem_err(err_b), .state_o(state_b),
      .stall_cycles(stall_b), .flush_count(flush_b)
   );

   function automatic logic [9:0] ev(input logic [2:0] st, input logic [5:0] o, input logic e);
      return {st, o, e};
   endfunction

   // Drive one cycle of inputs and record what both instances must show in it.
   task automatic step(input logic r, input logic iv, input logic rq, input logic ak,
                       input logic br, input logic [9:0] ea, input logic [9:0] eb,
                       input string nm);
      rst_n = r; imem_valid = iv; dmem_req = rq; dmem_ack = ak; branch_taken = br;
      exp_q.push_back({ea, eb});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [19:0] e;
         logic [9:0]  act_a, act_b;
         string       nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         act_a = {state_a, pc_en_a, sel_a, ifid_en_a, ifid_nop_a, idex_en_a, idex_nop_a, err_a};
         act_b = {state_b, pc_en_b, sel_b, ifid_en_b, ifid_nop_b, idex_en_b, idex_nop_b, err_b};
         checks += 2;
         if (act_a !== e[19:10]) begin
            errors++;
            $display("FAIL %s dut_a: got %b want %b", nm, act_a, e[19:10]);
         end
         if (act_b !== e[9:0]) begin
            errors++;
            $display("FAIL %s dut_b: got %b want %b", nm, act_b, e[9:0]);
         end
      end
   end

   task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   initial begin
      logic [9:0] rn, ra, rb;
      rn = ev(3'd1, O_RUN, 1'b0);

      // Reset held 3 cycles: first cycle state is still unknown, so it is not recorded.
      rst_n = 1'b0; imem_valid = 1'b1; dmem_req = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
      @(posedge clk);
      #1;
      step(0, 1, 0, 0, 0, ev(3'd0, O_BOOT, 0), ev(3'd0, O_BOOT, 0), "reset2");
      step(0, 1, 0, 0, 0, ev(3'd0, O_BOOT, 0), ev(3'd0, O_BOOT, 0), "reset3");
      step(1, 1, 0, 0, 0, ev(3'd0, O_BOOT, 0), ev(3'd0, O_BOOT, 0), "boot1");
      step(1, 1, 0, 0, 0, ev(3'd0, O_BOOT, 0), ev(3'd0, O_BOOT, 0), "boot2");
      step(1, 1, 0, 0, 0, rn, rn, "run_first");
      step(1, 1, 0, 0, 0, rn, rn, "run_steady");

      // Fetch bubble.
      step(1, 0, 0, 0, 0, ev(3'd1, O_FBUB, 0), ev(3'd1, O_FBUB, 0), "fetch_bubble");
      step(1, 1, 0, 0, 0, rn, rn, "after_bubble");

      // dmem stall with ack on the 4th stall cycle.
      step(1, 1, 1, 0, 0, ev(3'd1, O_STALL, 0), ev(3'd1, O_STALL, 0), "mem_stall1");
      step(1, 1, 1, 0, 0, ev(3'd2, O_STALL, 0), ev(3'd2, O_STALL, 0), "mem_stall2");
      step(1, 1, 1, 0, 0, ev(3'd2, O_STALL, 0), ev(3'd2, O_STALL, 0), "mem_stall3");
      step(1, 1, 1, 1, 0, ev(3'd2, O_STALL, 0), ev(3'd2, O_STALL, 0), "mem_stall4_ack");
      step(1, 1, 0, 0, 0, rn, rn, "mem_release");

      // Same-cycle req+ack: no stall.
      step(1, 1, 1, 1, 0, rn, rn, "req_ack_same");
      step(1, 1, 0, 0, 0, rn, rn, "after_req_ack");

      // Taken branch: a pads 2 fetches (one fetch missing in between), b returns to RUN at once.
      step(1, 1, 0, 0, 1, ev(3'd1, O_BR, 0), ev(3'd1, O_BR, 0), "branch");
      step(1, 1, 0, 0, 0, ev(3'd3, O_REDV, 0), rn, "redirect1");
      step(1, 0, 0, 0, 0, ev(3'd3, O_REDI, 0), ev(3'd1, O_FBUB, 0), "redirect2_nofetch");
      step(1, 1, 0, 0, 0, ev(3'd3, O_REDV, 0), rn, "redirect3");
      step(1, 1, 0, 0, 0, rn, rn, "after_redirect");

      // Ack withheld 10 cycles: a times out on its 5th MEM_WAIT cycle.
      step(1, 1, 1, 0, 0, ev(3'd1, O_STALL, 0), ev(3'd1, O_STALL, 0), "timeout_enter");
      for (int k = 1; k <= 9; k++) begin
         step(1, 1, 1, 0, 0, ev(3'd2, O_STALL, (k >= 5) ? 1'b1 : 1'b0),
              ev(3'd2, O_STALL, 0), $sformatf("timeout_wait%0d", k));
      end
      step(1, 1, 1, 1, 0, ev(3'd2, O_STALL, 1), ev(3'd2, O_STALL, 0), "timeout_ack");
      ra = ev(3'd1, O_RUN, 1'b1);
      step(1, 1, 0, 0, 0, ra, rn, "err_sticky1");
      step(1, 1, 0, 0, 0, ra, rn, "err_sticky2");

      // Reset in the middle of MEM_WAIT with dmem_req still high.
      step(1, 1, 1, 0, 0, ev(3'd1, O_STALL, 1), ev(3'd1, O_STALL, 0), "rst_mw_enter");
      step(1, 1, 1, 0, 0, ev(3'd2, O_STALL, 1), ev(3'd2, O_STALL, 0), "rst_mw_wait");
      step(0, 1, 1, 0, 0, ev(3'd2, O_STALL, 1), ev(3'd2, O_STALL, 0), "rst_mw_assert");
      step(1, 1, 1, 0, 0, ev(3'd0, O_BOOT, 0), ev(3'd0, O_BOOT, 0), "rst_mw_boot1");
      step(1, 1, 1, 0, 0, ev(3'd0, O_BOOT, 0), ev(3'd0, O_BOOT, 0), "rst_mw_boot2");
      step(1, 1, 0, 0, 0, rn, rn, "rst_mw_run");

      // Tail activity for the perf counters: one fetch bubble and one taken branch.
      step(1, 0, 0, 0, 0, ev(3'd1, O_FBUB, 0), ev(3'd1, O_FBUB, 0), "tail_bubble");
      step(1, 1, 0, 0, 1, ev(3'd1, O_BR, 0), ev(3'd1, O_BR, 0), "tail_branch");
      step(1, 1, 0, 0, 0, ev(3'd3, O_REDV, 0), rn, "tail_redirect1");
      step(1, 1, 0, 0, 0, ev(3'd3, O_REDV, 0), rn, "tail_redirect2");
      rb = rn;
      step(1, 1, 0, 0, 0, rb, rb, "tail_run");

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
      check32("stall_cycles_a", stall_a, 32'd1);
      check32("flush_count_a", flush_a, 32'd1);
      check32("stall_cycles_b", stall_b, 32'd1);
      check32("flush_count_b", flush_b, 32'd1);
`else
      check32("stall_cycles_a", stall_a, 32'd0);
      check32("flush_count_a", flush_a, 32'd0);
      check32("stall_cycles_b", stall_b, 32'd0);
      check32("flush_count_b", flush_b, 32'd0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Sequencing controller for the 3-stage IF/ID/EX RV32I pipeline.
- Owns every stall, bubble and flush decision:
  - boot sequencing after reset
  - instruction-fetch wait states
  - data-memory wait states via req/ack handshake
  - taken-branch redirect and squash
- Drives enable and NOP-injection selects for the PC, IF/ID and ID/EX registers. Injected bubbles are the canonical NOP, 32'h00000013 (ADDI x0,x0,0).

Parameters:
- BOOT_CYCLES, 2: cycles held in BOOT after reset release before the first PC advance; minimum 1.
- EXTRA_BUBBLES, 0: additional IF/ID bubbles after a taken-branch redirect (fetch-latency padding); range 0..7.
- MEM_TIMEOUT, 255: dmem wait cycles before mem_err sets; 8-bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- imem_valid  in  1  fetched instruction valid this cycle
- dmem_req  in  1  EX-stage instruction is a load/store awaiting completion
- dmem_ack  in  1  data memory completes the access this cycle
- branch_taken  in  1  EX-stage branch resolved taken (is_branch qualified)
- pc_en  out  1  PC register update enable
- pc_sel_target  out  1  PC loads branch target, not PC+4
- ifid_en  out  1  IF/ID register load enable
- ifid_nop  out  1  IF/ID loads NOP instead of fetched word
- idex_en  out  1  ID/EX register load enable
- idex_nop  out  1  ID/EX loads NOP control (reg_write=0, is_branch=0)
- mem_err  out  1  sticky dmem timeout flag
- state_o  out  3  current FSM state, for debug
- stall_cycles  out  32  perf counter (see Optional Feature)
- flush_count  out  32  perf counter (see Optional Feature)

Behaviour:

Reset (rst_n low at clk edge):
- State goes to BOOT; boot counter = 0; mem_err = 0; wait counter = 0.
- Outputs while in reset/BOOT: pc_en=0, pc_sel_target=0, ifid_en=1, ifid_nop=1, idex_en=1, idex_nop=1. The pipeline fills with NOPs.

State encoding: BOOT=0, RUN=1, MEM_WAIT=2, REDIRECT=3.

BOOT:
- Counts BOOT_CYCLES cycles, then goes to RUN.

RUN, evaluated in priority order:
- (a) dmem_req && !dmem_ack: full stall. pc_en=0, ifid_en=0, idex_en=0. Go to MEM_WAIT; wait counter = 1.
- (b) branch_taken: pc_en=1, pc_sel_target=1, ifid_en=1, ifid_nop=1, idex_en=1, idex_nop=1 (both younger instructions squashed). If EXTRA_BUBBLES>0, go to REDIRECT with counter = EXTRA_BUBBLES; else stay in RUN.
- (c) !imem_valid: fetch bubble. pc_en=0, ifid_en=1, ifid_nop=1, idex_en=1, idex_nop=0. The back end keeps draining.
- (d) Otherwise: all enables 1, all nop/sel 0.
- dmem_req && dmem_ack in the same cycle causes no stall.
- A branch in the same cycle as an unacked dmem_req is impossible (one EX instruction). If both are seen, (a) wins and the branch is re-sampled on exit.

MEM_WAIT:
- Holds the full stall; wait counter increments, saturating at 255.
- dmem_ack: next cycle behaves as RUN case (d) with all enables 1, entered via RUN.
- Counter reaching MEM_TIMEOUT: mem_err sets (sticky until reset). The FSM stays in MEM_WAIT; no forced exit.

REDIRECT:
- Outputs: pc_en=imem_valid, ifid_en=1, ifid_nop=1, idex_en=1, idex_nop=0.
- The counter decrements only on cycles with imem_valid=1; go to RUN when it reaches 0.
- branch_taken is ignored here (EX holds only bubbles).
- dmem_req is ignored here (EX holds only bubbles).

Other rules:
- Outputs are combinational from state + inputs. State and counters are registered.
- Reset mid-MEM_WAIT or mid-REDIRECT returns to BOOT immediately, with no ack required.

Optional Feature:
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments every cycle with pc_en=0 outside BOOT.
  - flush_count increments on each accepted taken branch.
  - Both are 32-bit, wrap on overflow and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset held 3 cycles, then released (BOOT_CYCLES=2) -> ifid_nop=idex_nop=1 and pc_en=0 for the 2 boot cycles; pc_en=1, state_o=1 on cycle 3.
- RUN, dmem_req=1 with dmem_ack after 4 cycles -> pc_en=ifid_en=idex_en=0 for exactly 4 cycles, all 1 the cycle after ack; same-cycle req+ack -> zero stall.
- branch_taken pulse in RUN, EXTRA_BUBBLES=0 -> one cycle of pc_sel_target=1, ifid_nop=1, idex_nop=1; RUN next cycle; flush_count=1 with PIPE_CTRL_PERF_EN.
- EXTRA_BUBBLES=2, imem_valid low 1 cycle inside REDIRECT -> 3 REDIRECT cycles total, ifid_nop=1 throughout, then RUN.
- MEM_TIMEOUT=5, dmem_ack withheld 10 cycles -> mem_err rises on wait cycle 5 and stays 1 after ack; cleared only by rst_n=0.
- rst_n asserted during MEM_WAIT -> state_o=0 next cycle, mem_err=0, all BOOT output values regardless of dmem_req.
